// File: rtl/aes_alarm_ctrl_if.sv
// Bundle between the AES fault-sensor array / host / key store and the alarm controller.
// Zeroize handshake: zeroize_req is held high until the key store answers with zeroize_ack;
// ack is only acted on while the request is up and is ignored at every other time.
interface aes_alarm_ctrl_if #(
    parameter int N_SENSORS = 16,
    parameter int CNT_W     = 8
);
    logic [N_SENSORS-1:0] alarm_in;
    logic [N_SENSORS-1:0] sensor_mask;
    logic                 clr;
    logic                 zeroize_ack;
    logic [N_SENSORS-1:0] status;
    logic [CNT_W-1:0]     event_cnt;
    logic                 alert;
    logic                 zeroize_req;
    logic                 locked;
    logic                 irq;
    logic [1:0]           state_dbg;

    modport master (
        output alarm_in, sensor_mask, clr, zeroize_ack,
        input  status, event_cnt, alert, zeroize_req, locked, irq, state_dbg
    );

    modport slave (
        input  alarm_in, sensor_mask, clr, zeroize_ack,
        output status, event_cnt, alert, zeroize_req, locked, irq, state_dbg
    );
endinterface

// File: rtl/aes_alarm_ctrl.sv
// AES fault-alarm controller: sticky status, saturating event counter, alert/zeroize/lock FSM.
// Optional macro AES_ALARM_DEBOUNCE_EN requires two consecutive alarm cycles per sensor.
module aes_alarm_ctrl #(
    parameter int N_SENSORS = 16,
    parameter int CNT_W     = 8,
    parameter int THRESHOLD = 4
) (
    input logic              clk,
    input logic              rst_n,
    aes_alarm_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALERT   = 2'd1,
        ZEROIZE = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [N_SENSORS-1:0] status_q, status_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 irq_q, irq_d;
    logic [N_SENSORS-1:0] act_raw;
    logic [N_SENSORS-1:0] act;
    logic                 any;
    logic [CNT_W-1:0]     nc;

    assign act_raw = bus.alarm_in & ~bus.sensor_mask;

`ifdef AES_ALARM_DEBOUNCE_EN
    logic [N_SENSORS-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= act_raw;
        end
    end

    assign act = act_raw & hist_q;
`else
    assign act = act_raw;
`endif

    assign any = |act;
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign nc  = (any && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        irq_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    status_d = status_q | act;
                    cnt_d    = nc;
                    irq_d    = 1'b1;
                    state_d  = (nc >= THR) ? ZEROIZE : ALERT;
                end else if (bus.clr) begin
                    status_d = '0;
                    cnt_d    = '0;
                end
            end
            ALERT: begin
                status_d = status_q | act;
                cnt_d    = nc;
                if (nc >= THR) begin
                    state_d = ZEROIZE;
                    irq_d   = 1'b1;
                end else if (bus.clr && !any) begin
                    state_d  = IDLE;
                    status_d = '0;
                    cnt_d    = '0;
                end
            end
            ZEROIZE: begin
                if (bus.zeroize_ack) begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            status_q <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.status      = status_q;
    assign bus.event_cnt   = cnt_q;
    assign bus.alert       = (state_q != IDLE);
    assign bus.zeroize_req = (state_q == ZEROIZE);
    assign bus.locked      = (state_q == LOCKED);
    assign bus.irq         = irq_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: doc/aes_alarm_ctrl.md
Name: aes_alarm_ctrl

Overview:
- Consumes the registered `alarm` outputs of the per-byte dual-rail AES fault sensors.
- Keeps sticky per-sensor status and counts fault events.
- Escalates through a response FSM: alert, then key zeroization with a handshake to the key store, then a permanent lock.
- Sits between the AES coprocessor's sensor array and the key register and host interrupt logic.

Parameters:
- N_SENSORS, 16, number of sensor alarm inputs (one per AES state byte).
- CNT_W, 8, width of the saturating event counter.
- THRESHOLD, 4, event count at or above which zeroization starts (1 to 2^CNT_W-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- alarm_in  input  N_SENSORS  alarm bits from the sensors, already registered.
- sensor_mask  input  N_SENSORS  1 = ignore that sensor (status and counting).
- clr  input  1  host request to clear status and counter; single-cycle pulse.
- zeroize_ack  input  1  key store confirms that the key has been wiped.
- status  output  N_SENSORS  sticky per-sensor fault flags.
- event_cnt  output  CNT_W  saturating count of fault-event cycles.
- alert  output  1  high whenever the state is not IDLE.
- zeroize_req  output  1  high in ZEROIZE, held until acknowledged.
- locked  output  1  high in LOCKED.
- irq  output  1  one-cycle pulse on escalation.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - status, event_cnt, alert, zeroize_req, locked and irq are all 0.
  - Reset overrides every other input, in every state, including mid-handshake.
- Qualified alarms:
  - act = alarm_in & ~sensor_mask.
  - any = |act.
  - Sampling is combinational; every effect is registered at the next edge.
- Per-cycle updates in IDLE and ALERT:
  - status <= status | act.
  - event_cnt <= min(event_cnt + any, 2^CNT_W-1). The counter saturates and never wraps.
- Frozen states: in ZEROIZE and LOCKED, status and event_cnt hold their values and alarm_in is ignored.
- FSM: states are IDLE, ALERT, ZEROIZE and LOCKED. Define nc = the next event_cnt value.
  - IDLE: if any and nc >= THRESHOLD, go to ZEROIZE. Else if any, go to ALERT. Else stay in IDLE.
  - ALERT: if nc >= THRESHOLD, go to ZEROIZE. Else if clr and !any, go to IDLE, with status <= 0 and event_cnt <= 0. Else stay in ALERT.
  - ZEROIZE: zeroize_req=1. When zeroize_ack=1, go to LOCKED (zeroize_req drops in the same edge). With no ack, stay indefinitely.
  - LOCKED: terminal; only rst_n leaves it. clr is ignored.
- clr handling:
  - clr in IDLE clears status and event_cnt; they are normally already 0.
  - If clr and any occur in the same cycle, the alarm wins: no clear, and the count increments.
- Outputs are decoded from registered state, so there is no combinational path from any input to any output.
  - alert = (state != IDLE).
  - zeroize_req = (state == ZEROIZE).
  - locked = (state == LOCKED).
- irq:
  - Registered. It is 1 for exactly the cycle after the edge that enters ALERT from IDLE, or ZEROIZE from IDLE or ALERT.
  - It is not asserted for ZEROIZE to LOCKED.
- Latency: an alarm present in cycle k is visible in status, event_cnt and the state from cycle k+1.
- zeroize_ack outside ZEROIZE is ignored.

Optional Feature:
- Macro: AES_ALARM_DEBOUNCE_EN.
- When defined:
  - Each act bit must be high in two consecutive cycles to qualify, with a per-sensor 1-cycle history register, reset to 0.
  - status, any and counting all use the debounced bits.
  - A sustained alarm counts once per cycle from its second cycle onward.
  - A single-cycle glitch is fully ignored.
  - Latency from the first alarm cycle becomes 2 cycles.
- When not defined: raw act is used and there are no extra registers.

Test Plan (N_SENSORS=4, CNT_W=4, THRESHOLD=3 unless stated):
- Reset/idle: rst_n=0 for 2 cycles, then alarm_in=0 for 10 cycles -> all outputs stay 0; state is IDLE.
- Single event, then clear: alarm_in=4'b0010 for 1 cycle -> next cycle status=0010, event_cnt=1, alert=1, irq=1 for 1 cycle. Then clr pulse -> status=0, event_cnt=0, alert=0.
- Escalation: alarm_in=4'b1000 for 3 consecutive cycles -> event_cnt=3, zeroize_req=1 from the cycle after the third, irq pulse. Then zeroize_ack after 5 cycles -> locked=1, zeroize_req=0; clr and alarms have no effect until rst_n.
- Mask and collision:
  - sensor_mask=4'b0001 with alarm_in=0001 -> no change.
  - From ALERT with event_cnt=1, clr together with alarm_in=0100 -> stays in ALERT, event_cnt=2, status retains bits.
- Saturation: THRESHOLD=15, CNT_W=4, alarm held 20 cycles -> event_cnt reaches 15 and the FSM enters ZEROIZE. Then hold zeroize_ack=0 for 30 cycles -> zeroize_req stays 1 and event_cnt stays 15 (no wrap).
- Debounce (with AES_ALARM_DEBOUNCE_EN): a 1-cycle pulse on alarm_in=0001 -> no response. A 3-cycle pulse -> event_cnt=2 and status=0001.
